// File: rtl/parser_if.sv
// Packet ingress beats plus parsed-record output, bundled for the parser.
interface parser_if;
   localparam int unsigned BEAT_W = 32;
   localparam int unsigned REC_W  = 296;

   logic [BEAT_W-1:0] dataIn;
   logic              dataIn_val;
   logic              dataIn_ready;
   logic              dataIN_last;
   logic [0:REC_W-1]  dataOut;
   logic              dataOut_val;
   logic              dataOut_ready;
   logic              packetLost;

   // Upstream beat source / downstream record sink side
   modport master (
      output dataIn, dataIn_val, dataIN_last, dataOut_ready,
      input  dataIn_ready, dataOut, dataOut_val, packetLost
   );

   // Parser side
   modport slave (
      input  dataIn, dataIn_val, dataIN_last, dataOut_ready,
      output dataIn_ready, dataOut, dataOut_val, packetLost
   );
endinterface

// File: rtl/parser.sv
// Streaming packet parser: header/sequence extraction, up to 29 payload bytes
// packed into one 296-bit record, per-stream sequence-gap detection.
// Optional build macro: OVERRUN_BACKPRESSURE_EN (stall input while a record
// is pending instead of overwriting it).
module parser #(
   parameter int unsigned NUM_STREAMS = 4
) (
   input  logic    clk,
   input  logic    reset_b,
   parser_if.slave bus
);
   localparam int unsigned REC_W     = 296;
   localparam int unsigned PAY_BYTES = 29;
   localparam int unsigned PAY_W     = PAY_BYTES * 8;
   localparam int unsigned PTR_W     = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
   localparam int unsigned BCNT_W    = 4;
   // Payload beat index past which every byte slot has been offered
   localparam int unsigned BCNT_SAT  = (PAY_BYTES + 3) / 4;

   typedef enum logic [1:0] {
      ST_HDR,
      ST_SEQ,
      ST_PAY
   } state_e;

   state_e                        state_q, state_d;
   logic                          run_q, run_d;
   logic [15:0]                   len_q, len_d;
   logic [15:0]                   stream_q, stream_d;
   logic [31:0]                   seq_q, seq_d;
   logic [BCNT_W-1:0]             bcnt_q, bcnt_d;
   logic [0:PAY_W-1]              pay_q, pay_d;
   logic [0:REC_W-1]              out_q, out_d;
   logic                          out_val_q, out_val_d;
   logic                          lost_q, lost_d;
   logic [NUM_STREAMS-1:0]        tbl_val_q, tbl_val_d;
   logic [NUM_STREAMS-1:0][15:0]  tbl_sid_q, tbl_sid_d;
   logic [NUM_STREAMS-1:0][31:0]  tbl_seq_q, tbl_seq_d;
   logic [PTR_W-1:0]              rr_q, rr_d;

   logic                          in_ready_c;
   logic                          beat_c;
   logic                          done_c;
   logic                          hit_c;
   logic                          free_c;
   logic [PTR_W-1:0]              hit_idx_c;
   logic [PTR_W-1:0]              free_idx_c;
   logic [PTR_W-1:0]              sel_idx_c;
   logic [31:0]                   hit_seq_c;

   // Input acceptance: optionally stall while an unaccepted record is pending
`ifdef OVERRUN_BACKPRESSURE_EN
   assign in_ready_c = run_q & ~(out_val_q & ~bus.dataOut_ready);
`else
   assign in_ready_c = run_q;
`endif

   assign beat_c = bus.dataIn_val & in_ready_c;
   // Only a final beat seen in the payload state completes a record; runts fall out here
   assign done_c = beat_c & bus.dataIN_last & (state_q == ST_PAY);

   // Stream table lookup: first matching entry, else lowest free, else round-robin victim
   always_comb begin
      hit_c      = 1'b0;
      hit_idx_c  = '0;
      hit_seq_c  = '0;
      free_c     = 1'b0;
      free_idx_c = '0;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
         if (!hit_c && tbl_val_q[i] && (tbl_sid_q[i] == stream_q)) begin
            hit_c     = 1'b1;
            hit_idx_c = PTR_W'(i);
            hit_seq_c = tbl_seq_q[i];
         end
         if (!free_c && !tbl_val_q[i]) begin
            free_c     = 1'b1;
            free_idx_c = PTR_W'(i);
         end
      end
      if (hit_c) begin
         sel_idx_c = hit_idx_c;
      end else if (free_c) begin
         sel_idx_c = free_idx_c;
      end else begin
         sel_idx_c = rr_q;
      end
   end

   // Next-state: framing FSM, field capture, record load, table update
   always_comb begin
      state_d   = state_q;
      run_d     = 1'b1;
      len_d     = len_q;
      stream_d  = stream_q;
      seq_d     = seq_q;
      bcnt_d    = bcnt_q;
      pay_d     = pay_q;
      out_d     = out_q;
      out_val_d = out_val_q;
      lost_d    = 1'b0;
      tbl_val_d = tbl_val_q;
      tbl_sid_d = tbl_sid_q;
      tbl_seq_d = tbl_seq_q;
      rr_d      = rr_q;

      if (out_val_q && bus.dataOut_ready) begin
         out_val_d = 1'b0;
      end

      if (beat_c) begin
         case (state_q)
            ST_HDR: begin
               len_d    = {bus.dataIn[23:16], bus.dataIn[31:24]};
               stream_d = {bus.dataIn[7:0],   bus.dataIn[15:8]};
               bcnt_d   = '0;
               pay_d    = '0;
               state_d  = ST_SEQ;
            end
            ST_SEQ: begin
               seq_d   = {bus.dataIn[7:0], bus.dataIn[15:8],
                          bus.dataIn[23:16], bus.dataIn[31:24]};
               state_d = ST_PAY;
            end
            default: begin
               // Slot k belongs to payload beat k/4; earliest byte sits in dataIn[31:24]
               for (int unsigned k = 0; k < PAY_BYTES; k++) begin
                  if (bcnt_q == BCNT_W'(k / 4)) begin
                     pay_d[8*k +: 8] = bus.dataIn[31 - 8*(k % 4) -: 8];
                  end
               end
               if (bcnt_q != BCNT_W'(BCNT_SAT)) begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         endcase
         if (bus.dataIN_last) begin
            state_d = ST_HDR;
         end
      end

      if (done_c) begin
         out_d[0 +: 16]      = len_q;
         out_d[16 +: 16]     = stream_q;
         out_d[32 +: 32]     = seq_q;
         out_d[64 +: PAY_W]  = pay_d;
         out_val_d           = 1'b1;
         if (hit_c) begin
            lost_d = (seq_q != (hit_seq_c + 32'd1));
         end else if (!free_c) begin
            rr_d = (rr_q == PTR_W'(NUM_STREAMS - 1)) ? '0 : rr_q + 1'b1;
         end
         for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
            if (sel_idx_c == PTR_W'(i)) begin
               tbl_val_d[i] = 1'b1;
               tbl_sid_d[i] = stream_q;
               tbl_seq_d[i] = seq_q;
            end
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset_b) begin
         state_q   <= ST_HDR;
         run_q     <= 1'b0;
         len_q     <= '0;
         stream_q  <= '0;
         seq_q     <= '0;
         bcnt_q    <= '0;
         pay_q     <= '0;
         out_q     <= '0;
         out_val_q <= 1'b0;
         lost_q    <= 1'b0;
         tbl_val_q <= '0;
         tbl_sid_q <= '0;
         tbl_seq_q <= '0;
         rr_q      <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         len_q     <= len_d;
         stream_q  <= stream_d;
         seq_q     <= seq_d;
         bcnt_q    <= bcnt_d;
         pay_q     <= pay_d;
         out_q     <= out_d;
         out_val_q <= out_val_d;
         lost_q    <= lost_d;
         tbl_val_q <= tbl_val_d;
         tbl_sid_q <= tbl_sid_d;
         tbl_seq_q <= tbl_seq_d;
         rr_q      <= rr_d;
      end
   end

   assign bus.dataIn_ready = in_ready_c;
   assign bus.dataOut      = out_q;
   assign bus.dataOut_val  = out_val_q;
   assign bus.packetLost   = lost_q;

endmodule

// File: tb/tb_parser.sv
// Randomised self-checking bench for parser against a record/table reference model.
module tb_parser;
   localparam int NS = 4;

   logic clk;
   logic reset_b;
   parser_if bus ();

   parser #(.NUM_STREAMS(NS)) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: pending record and stream table
   bit             exp_val;
   logic [0:295]   exp_rec;
   bit             ref_v   [NS];
   logic [15:0]    ref_sid [NS];
   logic [31:0]    ref_seq [NS];
   int             ref_rr;

   task automatic check(input string tag, input logic [295:0] got, input logic [295:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NS; i++) begin
         ref_v[i]   = 1'b0;
         ref_sid[i] = '0;
         ref_seq[i] = '0;
      end
      ref_rr  = 0;
      exp_val = 1'b0;
      exp_rec = '0;
   endfunction

   // Returns the expected loss flag and applies the table update rules
   function automatic bit model_done(input logic [15:0] sid, input logic [31:0] seq);
      int slot = -1;
      bit lost = 1'b0;
      for (int i = 0; i < NS; i++)
         if (slot < 0 && ref_v[i] && ref_sid[i] == sid) slot = i;
      if (slot >= 0) begin
         lost = (seq != ref_seq[slot] + 32'd1);
         ref_seq[slot] = seq;
      end else begin
         for (int i = 0; i < NS; i++)
            if (slot < 0 && !ref_v[i]) slot = i;
         if (slot < 0) begin
            slot   = ref_rr;
            ref_rr = (ref_rr + 1) % NS;
         end
         ref_v[slot]   = 1'b1;
         ref_sid[slot] = sid;
         ref_seq[slot] = seq;
      end
      return lost;
   endfunction

   function automatic logic [0:295] make_rec(input logic [15:0] len, input logic [15:0] sid,
                                            input logic [31:0] seq, input logic [31:0] words[$]);
      logic [0:295] r;
      logic [7:0]   b;
      int           k;
      r = '0;
      r[0:15]  = len;
      r[16:31] = sid;
      r[32:63] = seq;
      k = 0;
      foreach (words[i]) begin
         for (int j = 0; j < 4; j++) begin
            b = 8'(words[i] >> (8 * (3 - j)));
            if (k < 29) r[64 + 8*k +: 8] = b;
            k++;
         end
      end
      return r;
   endfunction

   task automatic send(input logic [31:0] beats[$], input bit mark_last);
      bit acc;
      int waitc;
      for (int i = 0; i < beats.size(); i++) begin
         bus.dataIn      = beats[i];
         bus.dataIn_val  = 1'b1;
         bus.dataIN_last = mark_last && (i == beats.size() - 1);
         waitc = 0;
         do begin
            @(negedge clk);
            acc = bus.dataIn_ready;
            @(posedge clk);
            #1;
            waitc++;
         end while (!acc && waitc < 200);
         if (!acc) check("beat_timeout", 296'(0), 296'(1));
      end
      bus.dataIn_val  = 1'b0;
      bus.dataIN_last = 1'b0;
   endtask

   task automatic drain();
      bus.dataOut_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.dataOut_ready = 1'b0;
      exp_val = 1'b0;
      check("drain_val", 296'(bus.dataOut_val), 296'(0));
   endtask

   task automatic run_packet(input logic [15:0] sid, input logic [31:0] seq, input logic [15:0] len,
                             input logic [31:0] words[$], input bit rdy);
      logic [31:0] beats[$];
      bit          exp_lost;
`ifdef OVERRUN_BACKPRESSURE_EN
      if (exp_val && !rdy) begin
         check("bp_ready", 296'(bus.dataIn_ready), 296'(0));
         drain();
      end
`else
      if (exp_val) check("ready_pending", 296'(bus.dataIn_ready), 296'(1));
`endif
      beats.push_back({len[7:0], len[15:8], sid[7:0], sid[15:8]});
      beats.push_back({seq[7:0], seq[15:8], seq[23:16], seq[31:24]});
      foreach (words[i]) beats.push_back(words[i]);
      bus.dataOut_ready = rdy;
      send(beats, 1'b1);
      bus.dataOut_ready = 1'b0;
      exp_lost = model_done(sid, seq);
      exp_rec  = make_rec(len, sid, seq, words);
      exp_val  = 1'b1;
      check("rec_val",   296'(bus.dataOut_val), 296'(1));
      check("rec_data",  296'(bus.dataOut), 296'(exp_rec));
      check("lost",      296'(bus.packetLost), 296'(exp_lost));
      @(posedge clk);
      #1;
      check("lost_once", 296'(bus.packetLost), 296'(0));
      check("val_hold",  296'(bus.dataOut_val), 296'(1));
   endtask

   task automatic runt(input int nb);
      logic [31:0] beats[$];
`ifdef OVERRUN_BACKPRESSURE_EN
      if (exp_val) drain();
`endif
      for (int i = 0; i < nb; i++) beats.push_back($urandom);
      send(beats, 1'b1);
      @(posedge clk);
      #1;
      check("runt_val",  296'(bus.dataOut_val), 296'(exp_val));
      check("runt_rec",  296'(bus.dataOut), 296'(exp_rec));
      check("runt_lost", 296'(bus.packetLost), 296'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w[$];
      logic [31:0] seq;
      logic [15:0] sid;
      logic [15:0] sids[7];
      bit          found;
      int          r;

      sids = '{16'd0, 16'd1, 16'd2, 16'hABCD, 16'hFFFF, 16'd12, 16'd13};
      bus.dataIn = '0; bus.dataIn_val = 1'b0; bus.dataIN_last = 1'b0; bus.dataOut_ready = 1'b0;
      model_reset();

      reset_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 296'(bus.dataIn_ready), 296'(0));
      check("rst_val",   296'(bus.dataOut_val), 296'(0));
      check("rst_data",  296'(bus.dataOut), 296'(0));
      check("rst_lost",  296'(bus.packetLost), 296'(0));
      reset_b = 1'b0;
      @(posedge clk);
      #1;
      check("ready_up",  296'(bus.dataIn_ready), 296'(1));

      // Directed sequence
      w = '{32'h01234562, 32'h01234563, 32'h01234564};
      run_packet(16'd12, 32'd1, 16'd20, w, 1'b0);
      check("t1_hdr", 296'(bus.dataOut[0:63]), 296'(64'h0014_000C_0000_0001));

      w = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
      run_packet(16'd13, 32'd1, 16'd25, w, 1'b0);

      w.delete();
      for (int i = 0; i < 7; i++) w.push_back($urandom);
      run_packet(16'd12, 32'd3, 16'd39, w, 1'b0);
      check("t3_byte29", 296'(bus.dataOut[288:295]), 296'(0));

      w.delete();
      for (int i = 0; i < 8; i++) w.push_back($urandom);
      run_packet(16'd12, 32'd4, 16'd40, w, 1'b1);

      w = '{32'h11223344};
      run_packet(16'd5, 32'hFFFF_FFFF, 16'd12, w, 1'b0);
      run_packet(16'd5, 32'd0, 16'd12, w, 1'b0);
      run_packet(16'd5, 32'd0, 16'd12, w, 1'b0);

      drain();
      runt(2);
      runt(1);
      w = '{32'hDEADBEEF, 32'h0BADF00D};
      run_packet(16'd7, 32'd10, 16'd16, w, 1'b0);

      for (int s = 0; s < 6; s++) begin
         w = '{$urandom};
         run_packet(16'(20 + s), 32'($urandom), 16'd12, w, 1'b0);
      end
      run_packet(16'd22, 32'd77, 16'd12, w, 1'b0);
      run_packet(16'd12, 32'd99, 16'd12, w, 1'b0);

      // Reset in the middle of a packet discards it and clears the table
      w = '{32'h0C000C00, 32'h01000000, 32'h55555555};
      send(w, 1'b0);
      reset_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_val",  296'(bus.dataOut_val), 296'(0));
      check("mid_rst_data", 296'(bus.dataOut), 296'(0));
      reset_b = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      w = '{32'h99887766, 32'h55443322};
      run_packet(16'd12, 32'd50, 16'd16, w, 1'b0);

      // Randomised traffic
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            runt($urandom_range(1, 2));
         end else if (r == 1) begin
            drain();
         end else begin
            sid   = sids[$urandom_range(0, 6)];
            found = 1'b0;
            seq   = $urandom;
            for (int i = 0; i < NS; i++)
               if (!found && ref_v[i] && ref_sid[i] == sid) begin
                  found = 1'b1;
                  if ($urandom_range(0, 3) != 0) seq = ref_seq[i] + 32'd1;
               end
            w.delete();
            for (int i = 0; i < $urandom_range(1, 9); i++) w.push_back($urandom);
            run_packet(sid, seq, 16'($urandom), w, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
